// File: rtl/mcp_src_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : mcp_src_launcher
//  Description : Source-domain launcher for a multi-cycle-path bus
//                synchronizer. Accepts one word over valid/ready and
//                registers it onto unsync_bus. It then drives bus_enable
//                high for HOLD_CYCLES and low for GAP_CYCLES before it
//                accepts the next word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcp_src_launcher #(
   parameter int DATA_WIDTH  = 8,
   parameter int HOLD_CYCLES = 4,   // must be >= 1
   parameter int GAP_CYCLES  = 2    // must be >= 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] unsync_bus,
   output logic                  bus_enable,
   output logic                  busy
);

   // Counter holds at most max(HOLD,GAP)-1; never narrower than one bit.
   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HOLD = 2'b01,
      ST_GAP  = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             accept;
   logic             enable_nxt;

   // Ready and busy decode from the state register only; in_valid only gates the load.
   assign in_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign accept   = in_valid & in_ready;

   // Next-state, counter and next-enable decode for the IDLE/HOLD/GAP sequence.
   always_comb begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = cnt;
      enable_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt  = ST_HOLD;
               cnt_nxt    = HOLD_LOAD;
               enable_nxt = 1'b1;
            end else begin
               state_nxt  = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               state_nxt  = ST_GAP;
               cnt_nxt    = GAP_LOAD;
            end else begin
               state_nxt  = ST_HOLD;
               cnt_nxt    = cnt - CNT_ONE;
               enable_nxt = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt == '0) begin
               state_nxt  = ST_IDLE;
            end else begin
               state_nxt  = ST_GAP;
               cnt_nxt    = cnt - CNT_ONE;
            end
         end
         default: begin
            // Unreachable encoding: return to IDLE with a cleared counter.
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
         end
      endcase
   end

   // State, counter and enable registers; the enable is a direct flop output so it cannot glitch.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         bus_enable <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         bus_enable <= enable_nxt;
      end
   end

   // Launched word changes only on accept, so it is stable for the whole HOLD and GAP.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         unsync_bus <= '0;
      end else if (accept) begin
         unsync_bus <= in_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mcp_src_launcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mcp_src_launcher
//  Description : Directed self-checking bench for mcp_src_launcher. It
//                drives three instances: default (4/2), minimum (1/1) and
//                an end-to-end instance (6/6). The end-to-end instance
//                feeds a slow destination synchronizer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcp_src_launcher;

   logic CLK  = 1'b0;
   logic dclk = 1'b0;
   logic RST  = 1'b1;

   always #5 CLK = ~CLK;
   // Destination clock, 3x slower, phase-shifted from the source clock.
   initial begin
      #7 dclk = 1'b1;
      forever #15 dclk = ~dclk;
   end

   // Instance A: default parameters
   logic [7:0] data_a = '0;
   logic       valid_a = 1'b0;
   logic       ready_a, en_a, busy_a;
   logic [7:0] bus_a;
   mcp_src_launcher #(.DATA_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(2)) u_a (
      .CLK(CLK), .RST(RST), .in_data(data_a), .in_valid(valid_a),
      .in_ready(ready_a), .unsync_bus(bus_a), .bus_enable(en_a), .busy(busy_a));

   // Instance B: minimum parameters
   logic [7:0] data_b = '0;
   logic       valid_b = 1'b0;
   logic       ready_b, en_b, busy_b;
   logic [7:0] bus_b;
   mcp_src_launcher #(.DATA_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_b (
      .CLK(CLK), .RST(RST), .in_data(data_b), .in_valid(valid_b),
      .in_ready(ready_b), .unsync_bus(bus_b), .bus_enable(en_b), .busy(busy_b));

   // Instance C: end-to-end, sized for a 2-stage synchronizer on a 3x slower clock
   logic [7:0] data_c = '0;
   logic       valid_c = 1'b0;
   logic       ready_c, en_c, busy_c;
   logic [7:0] bus_c;
   mcp_src_launcher #(.DATA_WIDTH(8), .HOLD_CYCLES(6), .GAP_CYCLES(6)) u_c (
      .CLK(CLK), .RST(RST), .in_data(data_c), .in_valid(valid_c),
      .in_ready(ready_c), .unsync_bus(bus_c), .bus_enable(en_c), .busy(busy_c));

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   // Destination synchronizer model: 2 flops plus an edge flop, capture on the rising edge
   logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
   logic [7:0] exp_q[$];
   int         rx_cnt = 0;
   int         tx_cnt = 0;

   always @(posedge dclk) begin
      s1 <= en_c;
      s2 <= s1;
      s3 <= s2;
   end

   always @(posedge dclk) begin
      if (s2 && !s3) begin
         rx_cnt++;
         if (exp_q.size() == 0)
            check("e2e_no_dup", 32'(rx_cnt), 32'(tx_cnt));
         else
            check("e2e_word", {24'd0, bus_c}, {24'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  rises;
      logic prev;
      logic acc;
      logic [7:0] w;

      // ---------------- reset state (asynchronous, no edge needed)
      #1 RST = 1'b0;
      #1;
      check("rst_ready", {31'd0, ready_a}, 32'd1);
      check("rst_busy",  {31'd0, busy_a},  32'd0);
      check("rst_en",    {31'd0, en_a},    32'd0);
      check("rst_bus",   {24'd0, bus_a},   32'd0);
      step();
      RST = 1'b1;
      step();
      step();
      check("idle_ready", {31'd0, ready_a}, 32'd1);
      check("idle_en",    {31'd0, en_a},    32'd0);

      // ---------------- single word 0xA5
      valid_a = 1'b1; data_a = 8'hA5;
      step();
      valid_a = 1'b0; data_a = 8'h00;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("single_en_%0d", i),    {31'd0, en_a},    {31'd0, (i < 4)});
         check($sformatf("single_ready_%0d", i), {31'd0, ready_a}, {31'd0, (i >= 6)});
         check($sformatf("single_busy_%0d", i),  {31'd0, busy_a},  {31'd0, (i < 6)});
         check($sformatf("single_bus_%0d", i),   {24'd0, bus_a},   32'hA5);
         step();
      end

      // ---------------- back-to-back 0x11 then 0x22 with valid held
      valid_a = 1'b1; data_a = 8'h11;
      step();
      data_a = 8'h22;
      rises = 1; prev = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (en_a && !prev) rises++;
         prev = en_a;
         check($sformatf("b2b_en_%0d", i),  {31'd0, en_a},  {31'd0, ((i % 7) < 4)});
         check($sformatf("b2b_bus_%0d", i), {24'd0, bus_a}, (i < 7) ? 32'h11 : 32'h22);
         if (i == 7) valid_a = 1'b0;
         step();
      end
      check("b2b_pulses", 32'(rises), 32'd2);
      check("b2b_ready_end", {31'd0, ready_a}, 32'd1);

      // ---------------- stall: valid pulsed during HOLD and GAP
      valid_a = 1'b1; data_a = 8'h77;
      step();
      valid_a = 1'b0;
      rises = 1; prev = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (en_a && !prev) rises++;
         prev = en_a;
         check($sformatf("stall_en_%0d", i),  {31'd0, en_a},  {31'd0, (i < 4)});
         check($sformatf("stall_bus_%0d", i), {24'd0, bus_a}, 32'h77);
         if (i == 1 || i == 4) begin
            valid_a = 1'b1; data_a = 8'h99;
         end else begin
            valid_a = 1'b0; data_a = 8'h00;
         end
         step();
      end
      check("stall_pulses", 32'(rises), 32'd1);

      // ---------------- reset mid-HOLD, then relaunch
      valid_a = 1'b1; data_a = 8'h3C;
      step();
      valid_a = 1'b0;
      step();
      step();
      check("midhold_en_before", {31'd0, en_a},  32'd1);
      check("midhold_bus_before", {24'd0, bus_a}, 32'h3C);
      RST = 1'b0;
      #1;
      check("midhold_rst_en",    {31'd0, en_a},    32'd0);
      check("midhold_rst_bus",   {24'd0, bus_a},   32'd0);
      check("midhold_rst_ready", {31'd0, ready_a}, 32'd1);
      check("midhold_rst_busy",  {31'd0, busy_a},  32'd0);
      step();
      step();
      RST = 1'b1;
      step();
      check("post_rst_idle_en", {31'd0, en_a},    32'd0);
      check("post_rst_ready",   {31'd0, ready_a}, 32'd1);
      valid_a = 1'b1; data_a = 8'h5A;
      step();
      valid_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("relaunch_en_%0d", i),    {31'd0, en_a},    {31'd0, (i < 4)});
         check($sformatf("relaunch_ready_%0d", i), {31'd0, ready_a}, {31'd0, (i >= 6)});
         check($sformatf("relaunch_bus_%0d", i),   {24'd0, bus_a},   32'h5A);
         step();
      end

      // ---------------- minimum parameters, valid held for two words
      valid_b = 1'b1; data_b = 8'hC3;
      step();
      data_b = 8'h3C;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("min_en_%0d", i),    {31'd0, en_b},    {31'd0, ((i % 3) == 0)});
         check($sformatf("min_ready_%0d", i), {31'd0, ready_b}, {31'd0, ((i % 3) == 2)});
         check($sformatf("min_bus_%0d", i),   {24'd0, bus_b},   (i < 3) ? 32'hC3 : 32'h3C);
         if (i == 3) valid_b = 1'b0;
         step();
      end

      // ---------------- end-to-end through the slow destination model
      for (int n = 0; n < 100; n++) begin
         w = 8'($urandom_range(0, 255));
         data_c  = w;
         valid_c = 1'b1;
         acc = 1'b0;
         for (int t = 0; t < 40 && !acc; t++) begin
            acc = ready_c;
            step();
         end
         check("e2e_accept", {31'd0, acc}, 32'd1);
         exp_q.push_back(w);
         tx_cnt++;
         valid_c = 1'b0;
         repeat ($urandom_range(0, 3)) step();
      end
      repeat (30) step();
      check("e2e_count", 32'(rx_cnt), 32'd100);
      check("e2e_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
